dmem_responder: RTL and testbench

- Responder side of the CPU data-memory interface. It serves load/store requests from the datapath's memory port over a valid/ready handshake.
- Supports byte, halfword and word accesses with sign/zero extension, alignment and range checking, and a configurable number of wait states.
- Backed by an internal word array. Replaces the zero-latency data memory so the CPU can be tested against realistic memory timing.

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_responder_lane_align.sv | 39 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - access size and state encodings shared by the data-memory responder
package dmem_defs;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Reserved size is reported separately, so it never counts as misaligned here.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_H:  is_misaligned = addr_lo[0];
      SIZE_W:  is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - byte-lane merge for stores and lane extract/extend for loads
module lane_align
  import dmem_defs::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = old_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = old_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    store_word = old_word;
    load_data  = old_word;
    case (size)
      SIZE_B: begin
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SIZE_H: begin
        store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: begin
        store_word = wdata;
        load_data  = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with wait states over a word array
module dmem_responder
  import dmem_defs::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t state, state_n;
  logic [3:0]  cnt, cnt_n;

  logic        lat_write;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic             cur_write;
  logic             cur_unsigned;
  logic [1:0]       cur_size;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      old_word;
  logic [31:0]      store_word;
  logic [31:0]      load_data;

  logic accept;
  logic commit;
  logic range_err;
  logic req_err;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  assign range_err = (req_addr < BASE_ADDR) ||
                     (((req_addr - BASE_ADDR) >> 2) >= 32'(DEPTH_WORDS));
  assign req_err   = (req_size == SIZE_RSVD) ||
                     is_misaligned(mem_size_t'(req_size), req_addr[1:0]) ||
                     range_err;

  // With zero wait states the commit happens on the acceptance edge, so the
  // access path must see the live request rather than the latched copy.
  assign cur_write    = (state == IDLE) ? req_write    : lat_write;
  assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
  assign cur_size     = (state == IDLE) ? req_size     : lat_size;
  assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
  assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

  assign cur_idx  = IDX_W'((cur_addr - BASE_ADDR) >> 2);
  assign old_word = mem[cur_idx];

  lane_align u_lane_align (
    .old_word    (old_word),
    .wdata       (cur_wdata),
    .size        (cur_size),
    .addr_lo     (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .store_word  (store_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            state_n = RESP;
          end else if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_n = RESP;
          end else begin
            cnt_n   = 4'(WAIT_STATES - 1);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      resp_rdata   <= 32'd0;
      resp_error   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_size     <= req_size;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
      end
      if (accept && req_err) begin
        resp_error <= 1'b1;
        resp_rdata <= 32'd0;
      end else if (commit) begin
        resp_error <= 1'b0;
        resp_rdata <= cur_write ? 32'd0 : load_data;
      end
    end
  end

  // The array has no reset; a store still pending when reset rises is dropped.
  always_ff @(posedge clk) begin
    if (commit && cur_write && !reset) mem[cur_idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed checks of dmem_responder at 1, 3 and 0 wait states
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [2:0]  req_unsigned;
  logic [2:0]  resp_ready;
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  resp_valid;
  wire  [2:0]  resp_error;
  wire  [31:0] resp_rdata [3];

  int n_checks = 0;
  int n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency counts cycles from the acceptance edge to the first cycle with resp_valid.
  task automatic xact(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int  n;
    bit  seen;
    bit  stable;
    bit  rdy_seen;
    rd  = 32'hx;
    er  = 1'bx;
    lat = -1;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (resp_valid[d]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) begin
      check_val("resp_timeout", 32'd0, 32'd1);
      return;
    end
    lat = n + 1;
    rd  = resp_rdata[d];
    er  = resp_error[d];
    if (hold > 0) begin
      stable   = 1'b1;
      rdy_seen = 1'b0;
      for (int i = 0; i < hold; i++) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'b10;
        req_addr[d] = 32'h10; req_wdata[d] = 32'h5555_5555;
        @(posedge clk); #1;
        if (!resp_valid[d] || resp_rdata[d] !== rd || resp_error[d] !== er) stable = 1'b0;
        if (req_ready[d]) rdy_seen = 1'b1;
      end
      req_valid[d] = 1'b0;
      check_val("bp_stable", 32'(stable), 32'd1);
      check_val("bp_req_ready", 32'(rdy_seen), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check_val("idle_after_resp", {30'd0, resp_valid[d], req_ready[d]}, 32'd1);
  endtask

  task automatic run(input string tag, input int d, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, wr, sz, uns, addr, wd, 0, rd, er, lat);
    check_val({tag, "_rdata"}, rd, exp_rd);
    check_val({tag, "_error"}, 32'(er), 32'(exp_er));
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    reset = 3'b111; req_valid = 3'b000; req_write = 3'b000;
    req_unsigned = 3'b000; resp_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_size[i] = 2'b10; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check_val("rst_resp_rdata", resp_rdata[0], 32'd0);
    check_val("rst_resp_error", 32'(resp_error[0]), 32'd0);
    @(negedge clk);
    reset = 3'b000;

    run("sw_word",   0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2);
    run("lw_word",   0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2);
    run("sb_13",     0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_007F, 32'h0,         1'b0, 2);
    run("lw_sb",     0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h7FAD_BEEF, 1'b0, 2);
    run("lb_13",     0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'h0000_007F, 1'b0, 2);
    run("sh_10",     0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_8001, 32'h0,         1'b0, 2);
    run("lh_10",     0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,         32'hFFFF_8001, 1'b0, 2);
    run("lhu_10",    0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000_8001, 1'b0, 2);
    run("lbu_11",    0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         32'h0000_0080, 1'b0, 2);
    run("lb_12",     0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0,         32'hFFFF_FFAD, 1'b0, 2);
    run("lh_12",     0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'h0000_7FAD, 1'b0, 2);

    run("lw_mis",    0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0,         32'h0,         1'b1, 1);
    run("sh_mis",    0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_1234, 32'h0,         1'b1, 1);
    run("lw_nochg",  0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h7FAD_8001, 1'b0, 2);
    run("size_rsvd", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1, 1);
    run("lw_range",  0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,         1'b1, 1);
    run("sw_last",   0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0BAD_F00D, 32'h0,        1'b0, 2);
    run("lw_last",   0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'h0BAD_F00D, 1'b0, 2);

    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    check_val("bp_rdata", rd, 32'h7FAD_8001);
    check_val("bp_error", 32'(er), 32'd0);
    run("bp_nochg",  0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h7FAD_8001, 1'b0, 2);

    run("ws3_sw",    1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA, 32'h0,         1'b0, 4);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'b10;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h20; req_wdata[1] = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check_val("ws3_in_wait", {30'd0, resp_valid[1], req_ready[1]}, 32'd0);
    #2;
    reset[1] = 1'b1;
    #1;
    check_val("ws3_rst_async", {30'd0, resp_valid[1], req_ready[1]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset[1] = 1'b0;
    run("ws3_lw",    1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'hAAAA_AAAA, 1'b0, 4);

    run("ws0_sw",    2, 1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFE_F00D, 32'h0,         1'b0, 1);
    run("ws0_lw",    2, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         32'hCAFE_F00D, 1'b0, 1);
    run("ws0_lbu",   2, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0,         32'h0000_00CA, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
